// File: rtl/rv_sdram_master_if.sv
// rv_sdram_master_if: softcore valid/ready bus plus the SDRAM controller's toggle-handshake port.
// The master modport is the bridge side; slave is the softcore/controller side.
interface rv_sdram_master_if #(
    parameter int ADDR_WIDTH = 23
);
    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;
    logic [19:0]           rv_addr;
    logic [15:0]           rv_din;
    logic [1:0]            rv_ds;
    logic                  rv_we;
    logic                  rv_req;
    logic                  rv_req_ack;
    logic [15:0]           rv_dout;
    modport master (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, rv_req_ack, rv_dout,
        output mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req
    );
    modport slave (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, rv_req_ack, rv_dout,
        input  mem_ready, mem_rdata, rv_addr, rv_din, rv_ds, rv_we, rv_req
    );
endinterface

// File: rtl/rv_sdram_master.sv
// rv_sdram_master: splits 32-bit softcore accesses into low/high 16-bit toggle-handshake SDRAM transactions.
// Optional ack watchdog enabled by defining RV_SDRAM_TIMEOUT_EN.
module rv_sdram_master #(
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    rv_sdram_master_if.master    bus,
    output logic                 o_busy,
    output logic                 o_timeout
);
    typedef enum logic [2:0] {IDLE, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT, DONE} state_t;
    state_t      state;
    logic [18:0] idx;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        we;
    logic        ack_match;
    logic [1:0]  hi_ds;
    assign we        = |wstrb;
    assign ack_match = bus.rv_req_ack == bus.rv_req;
    assign hi_ds     = we ? wstrb[3:2] : 2'b11;
    assign o_busy    = state != IDLE;
    if (ADDR_WIDTH < 21 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("rv_sdram_master: ADDR_WIDTH must be >= 21 and TIMEOUT_CYCLES within 1..65535");
    end
`ifdef RV_SDRAM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
    logic        tmo_flag;
    assign o_timeout = tmo_flag;
`else
    assign o_timeout = 1'b0;
`endif
    // Half fields are loaded one cycle ahead of the toggle so they are stable before it.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state         <= IDLE;
            idx           <= '0;
            wdata         <= '0;
            wstrb         <= '0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            bus.rv_addr   <= '0;
            bus.rv_din    <= '0;
            bus.rv_ds     <= '0;
            bus.rv_we     <= 1'b0;
            bus.rv_req    <= 1'b0;
`ifdef RV_SDRAM_TIMEOUT_EN
            tmo_cnt       <= '0;
            tmo_flag      <= 1'b0;
`endif
        end else begin
            bus.mem_ready <= 1'b0;
            case (state)
                IDLE: if (bus.mem_valid && !bus.mem_ready) begin
                    idx           <= bus.mem_addr[20:2];
                    wdata         <= bus.mem_wdata;
                    wstrb         <= bus.mem_wstrb;
                    bus.mem_rdata <= '0;
                    bus.rv_addr   <= {bus.mem_addr[20:2], 1'b0};
                    bus.rv_din    <= bus.mem_wdata[15:0];
                    bus.rv_ds     <= |bus.mem_wstrb ? bus.mem_wstrb[1:0] : 2'b11;
                    bus.rv_we     <= |bus.mem_wstrb;
                    state         <= LO_REQ;
                end
                LO_REQ: if (we && wstrb[1:0] == 2'b00) begin
                    bus.rv_addr <= {idx, 1'b1};
                    bus.rv_din  <= wdata[31:16];
                    bus.rv_ds   <= hi_ds;
                    state       <= HI_REQ;
                end else begin
                    bus.rv_req <= ~bus.rv_req;
                    state      <= LO_WAIT;
                end
                LO_WAIT: if (ack_match) begin
                    bus.mem_rdata[15:0] <= bus.rv_dout;
                    bus.rv_addr         <= {idx, 1'b1};
                    bus.rv_din          <= wdata[31:16];
                    bus.rv_ds           <= hi_ds;
                    state               <= HI_REQ;
                end
                HI_REQ: if (we && wstrb[3:2] == 2'b00) begin
                    state <= DONE;
                end else begin
                    bus.rv_req <= ~bus.rv_req;
                    state      <= HI_WAIT;
                end
                HI_WAIT: if (ack_match) begin
                    bus.mem_rdata[31:16] <= bus.rv_dout;
                    state                <= DONE;
                end
                DONE: begin
                    bus.mem_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef RV_SDRAM_TIMEOUT_EN
            // Watchdog overrides the wait states; resyncing the request bit drops the stale request.
            if ((state == LO_WAIT || state == HI_WAIT) && !ack_match) begin
                tmo_cnt <= tmo_cnt + 16'd1;
                if (tmo_cnt == TMO_LAST) begin
                    tmo_flag      <= 1'b1;
                    bus.mem_rdata <= 32'hDEAD_BEEF;
                    bus.rv_req    <= bus.rv_req_ack;
                    state         <= DONE;
                end
            end else if (state == LO_REQ || state == HI_REQ) begin
                tmo_cnt <= '0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_rv_sdram_master.sv
// tb_rv_sdram_master: randomized and directed checks of rv_sdram_master against a word-level memory model
// and an SDRAM responder with programmable ack latency.
module tb_rv_sdram_master;
    localparam int AW = 23;
`ifdef RV_SDRAM_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, timeout;
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    int   lat = 0;
    bit   mute = 1'b0;
    int   wait_cnt;
    int   tog_since_rst;
    bit [15:0] w;
    bit [15:0] sdram [bit [19:0]];
    bit [31:0] ref_mem [bit [18:0]];

    typedef struct {
        logic [19:0] addr;
        logic [15:0] din;
        logic [1:0]  ds;
        logic        we;
        int          cyc;
    } tog_t;
    tog_t tog_q[$];
    tog_t cur;
    logic prev_req;
    logic [38:0] prev_fields;

    rv_sdram_master_if #(.ADDR_WIDTH(AW)) bus();

    rv_sdram_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_resetn(rst_n), .bus(bus), .o_busy(busy), .o_timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // SDRAM responder: acks lat cycles after it sees an outstanding request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rv_req_ack <= 1'b0;
            bus.rv_dout    <= '0;
            wait_cnt       <= 0;
        end else if (bus.rv_req != bus.rv_req_ack && !mute) begin
            if (wait_cnt >= lat) begin
                bus.rv_req_ack <= bus.rv_req;
                wait_cnt       <= 0;
                if (bus.rv_we) begin
                    w = sdram.exists(bus.rv_addr) ? sdram[bus.rv_addr] : 16'h0;
                    if (bus.rv_ds[0]) w[7:0] = bus.rv_din[7:0];
                    if (bus.rv_ds[1]) w[15:8] = bus.rv_din[15:8];
                    sdram[bus.rv_addr] = w;
                end else begin
                    bus.rv_dout <= sdram.exists(bus.rv_addr) ? sdram[bus.rv_addr] : 16'h0;
                end
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    // Toggle monitor: records each request and checks field stability around it
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_req      = 1'b0;
            tog_since_rst = 0;
        end else begin
            if (bus.rv_req != prev_req) begin
                cur = '{bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, cycle};
                tog_q.push_back(cur);
                tog_since_rst++;
                prev_req = bus.rv_req;
                checks++;
                if ({bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we} !== prev_fields) begin
                    errors++;
                    $display("FAIL pre_toggle_stable: fields %h before toggle, %h at toggle", prev_fields,
                             {bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we});
                end
            end else if (bus.rv_req != bus.rv_req_ack) begin
                checks++;
                if ({bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we} !== {cur.addr, cur.din, cur.ds, cur.we}) begin
                    errors++;
                    $display("FAIL field_stable: got %h, required %h", {bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we},
                             {cur.addr, cur.din, cur.ds, cur.we});
                end
            end
            prev_fields = {bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we};
        end
    end

    function automatic int exp_toggles(input logic [3:0] ws);
        return ws == 4'h0 ? 2 : int'(|ws[1:0]) + int'(|ws[3:2]);
    endfunction

    task automatic access(input logic [22:0] a, input logic [31:0] wd, input logic [3:0] ws, input bit hold,
                          output logic [31:0] rd, output int n, output int ready_cyc);
        bit [31:0] m;
        n = 0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = a;
        bus.mem_wdata = wd;
        bus.mem_wstrb = ws;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_ready && n < 300);
        checks++;
        if (!bus.mem_ready) begin
            errors++;
            $display("FAIL access_ready: no o_mem_ready after %0d cycles, required within 300", n);
        end
        rd = bus.mem_rdata;
        ready_cyc = cycle;
        m = ref_mem.exists(a[20:2]) ? ref_mem[a[20:2]] : 32'h0;
        for (int b = 0; b < 4; b++) if (ws[b]) m[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a[20:2]] = m;
        if (!hold) begin
            bus.mem_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.mem_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ready_pulse: ready=%b busy=%b after completion, required 0 0", bus.mem_ready, busy);
            end
        end
    endtask

    task automatic test_reset;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_ready, bus.mem_rdata, bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {bus.mem_ready, bus.mem_rdata, bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req});
        end
        checks++;
        if ({busy, timeout} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: busy/timeout=%b, required 00", {busy, timeout});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read;
        logic [31:0] rd;
        int n, rc, base;
        sdram[20'h33000] = 16'h1234;
        sdram[20'h33001] = 16'hABCD;
        lat = 3;
        base = tog_q.size();
        access(23'h066000, 32'h0, 4'h0, 1'b0, rd, n, rc);
        checks++;
        if (rd !== 32'hABCD1234) begin
            errors++;
            $display("FAIL read_data: got %h, required abcd1234", rd);
        end
        checks++;
        if (tog_q.size() != base + 2) begin
            errors++;
            $display("FAIL read_toggles: got %0d, required 2", tog_q.size() - base);
        end else begin
            checks++;
            if (tog_q[base].addr !== 20'h33000 || tog_q[base+1].addr !== 20'h33001) begin
                errors++;
                $display("FAIL read_addr: got %h %h, required 33000 33001", tog_q[base].addr, tog_q[base+1].addr);
            end
            checks++;
            if ({tog_q[base].ds, tog_q[base].we, tog_q[base+1].ds, tog_q[base+1].we} !== 6'b110110) begin
                errors++;
                $display("FAIL read_ds_we: got ds/we %b%b %b%b, required 110 110",
                         tog_q[base].ds, tog_q[base].we, tog_q[base+1].ds, tog_q[base+1].we);
            end
        end
        ref_mem[19'h19800] = 32'hABCD1234;
    endtask

    task automatic test_writes;
        logic [31:0] rd;
        int n_full, n_single, rc, base;
        lat = 3;
        base = tog_q.size();
        access(23'h000100, 32'hCAFEF00D, 4'b1111, 1'b0, rd, n_full, rc);
        checks++;
        if (tog_q.size() != base + 2) begin
            errors++;
            $display("FAIL wfull_toggles: got %0d, required 2", tog_q.size() - base);
        end else begin
            checks++;
            if (tog_q[base].din !== 16'hF00D || tog_q[base+1].din !== 16'hCAFE) begin
                errors++;
                $display("FAIL wfull_din: got %h %h, required f00d cafe", tog_q[base].din, tog_q[base+1].din);
            end
            checks++;
            if ({tog_q[base].ds, tog_q[base].we, tog_q[base+1].ds, tog_q[base+1].we} !== 6'b111111) begin
                errors++;
                $display("FAIL wfull_ds_we: got %b%b %b%b, required 111 111",
                         tog_q[base].ds, tog_q[base].we, tog_q[base+1].ds, tog_q[base+1].we);
            end
        end
        base = tog_q.size();
        access(23'h000204, 32'h5A5A1357, 4'b0100, 1'b0, rd, n_single, rc);
        checks++;
        if (tog_q.size() != base + 1) begin
            errors++;
            $display("FAIL wsingle_toggles: got %0d, required 1", tog_q.size() - base);
        end else begin
            checks++;
            if (tog_q[base].addr !== 20'h00103 || tog_q[base].ds !== 2'b01 || tog_q[base].din !== 16'h5A5A) begin
                errors++;
                $display("FAIL wsingle_fields: addr=%h ds=%b din=%h, required 00103 01 5a5a",
                         tog_q[base].addr, tog_q[base].ds, tog_q[base].din);
            end
        end
        checks++;
        if (n_single >= n_full) begin
            errors++;
            $display("FAIL wsingle_latency: single-half %0d cycles, required fewer than full %0d", n_single, n_full);
        end
        access(23'h000100, 32'h0, 4'h0, 1'b0, rd, n_full, rc);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wfull_readback: got %h, required cafef00d", rd);
        end
        access(23'h000204, 32'h0, 4'h0, 1'b0, rd, n_full, rc);
        checks++;
        if (rd !== 32'h005A0000) begin
            errors++;
            $display("FAIL wsingle_readback: got %h, required 005a0000", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd1, rd2;
        int n1, n2, r1, r2, base, b2;
        lat = 1;
        base = tog_q.size();
        access(23'h066000, 32'h0, 4'h0, 1'b1, rd1, n1, r1);
        b2 = tog_q.size();
        access(23'h000100, 32'h0, 4'h0, 1'b0, rd2, n2, r2);
        checks++;
        if (rd1 !== ref_mem[19'h19800] || rd2 !== ref_mem[19'h00040]) begin
            errors++;
            $display("FAIL b2b_data: got %h %h, required %h %h", rd1, rd2, ref_mem[19'h19800], ref_mem[19'h00040]);
        end
        checks++;
        if (tog_q.size() != base + 4) begin
            errors++;
            $display("FAIL b2b_toggles: got %0d, required 4", tog_q.size() - base);
        end else begin
            checks++;
            if (tog_q[b2].cyc - r1 < 2) begin
                errors++;
                $display("FAIL b2b_gap: next toggle %0d cycles after ready, required at least 2", tog_q[b2].cyc - r1);
            end
        end
        checks++;
        if (bus.rv_req !== tog_since_rst[0] || bus.rv_req !== bus.rv_req_ack) begin
            errors++;
            $display("FAIL b2b_parity: req=%b ack=%b, required %b both", bus.rv_req, bus.rv_req_ack, tog_since_rst[0]);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, exp_rd, wd;
        logic [22:0] a;
        logic [3:0]  ws;
        logic [18:0] pool [4];
        int n, rc, base, k;
        pool[0] = 19'h00040;
        pool[1] = 19'h00081;
        pool[2] = 19'h12345;
        pool[3] = 19'h7FFFF;
        for (int t = 0; t < 24; t++) begin
            a   = {2'($urandom), pool[$urandom_range(0, 3)], 2'($urandom)};
            wd  = $urandom;
            ws  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            lat = $urandom_range(0, 3);
            exp_rd = ref_mem.exists(a[20:2]) ? ref_mem[a[20:2]] : 32'h0;
            base = tog_q.size();
            access(a, wd, ws, 1'b0, rd, n, rc);
            if (ws == 4'h0) begin
                checks++;
                if (rd !== exp_rd) begin
                    errors++;
                    $display("FAIL rand_read[%0d]: addr %h got %h, required %h", t, a, rd, exp_rd);
                end
            end
            checks++;
            if (tog_q.size() != base + exp_toggles(ws)) begin
                errors++;
                $display("FAIL rand_toggles[%0d]: got %0d, required %0d", t, tog_q.size() - base, exp_toggles(ws));
            end else begin
                k = base;
                for (int h = 0; h < 2; h++) begin
                    if (ws == 4'h0 || ws[2*h +: 2] != 2'b00) begin
                        checks++;
                        if ({tog_q[k].addr, tog_q[k].din, tog_q[k].ds, tog_q[k].we} !==
                            {a[20:2], 1'(h), wd[16*h +: 16], (ws == 4'h0) ? 2'b11 : ws[2*h +: 2], ws != 4'h0}) begin
                            errors++;
                            $display("FAIL rand_fields[%0d] half %0d: got %h %h %b %b, required %h %h %b %b", t, h,
                                     tog_q[k].addr, tog_q[k].din, tog_q[k].ds, tog_q[k].we, {a[20:2], 1'(h)},
                                     wd[16*h +: 16], (ws == 4'h0) ? 2'b11 : ws[2*h +: 2], ws != 4'h0);
                        end
                        k++;
                    end
                end
            end
        end
    endtask

`ifdef RV_SDRAM_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] rd;
        int n, rc, base;
        mute = 1'b1;
        base = tog_q.size();
        access(23'h000100, 32'h0, 4'h0, 1'b0, rd, n, rc);
        checks++;
        if (rd !== 32'hDEADBEEF || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_result: rdata=%h timeout=%b, required deadbeef 1", rd, timeout);
        end
        checks++;
        if (tog_q.size() <= base || rc - tog_q[base].cyc < 16 || rc - tog_q[base].cyc > 20) begin
            errors++;
            $display("FAIL timeout_latency: ready %0d cycles after toggle, required 16..20",
                     tog_q.size() > base ? rc - tog_q[base].cyc : -1);
        end
        checks++;
        if (bus.rv_req !== bus.rv_req_ack) begin
            errors++;
            $display("FAIL timeout_resync: req=%b ack=%b, required equal", bus.rv_req, bus.rv_req_ack);
        end
        mute = 1'b0;
        lat = 1;
        access(23'h066000, 32'h0, 4'h0, 1'b0, rd, n, rc);
        checks++;
        if (rd !== 32'hABCD1234 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: rdata=%h timeout=%b, required abcd1234 1", rd, timeout);
        end
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] rd;
        int n, rc, base;
        bit seen_ready;
        seen_ready = 1'b0;
        lat = 12;
        n = 0;
        base = tog_q.size();
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 23'h066000;
        bus.mem_wstrb = 4'h0;
        while (tog_q.size() < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.mem_ready) seen_ready = 1'b1;
        end
        checks++;
        if (tog_q.size() < base + 2) begin
            errors++;
            $display("FAIL midrst_reach: %0d toggles, required 2 before reset", tog_q.size() - base);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.mem_valid = 1'b0;
        #1;
        checks++;
        if ({bus.mem_ready, bus.mem_rdata, bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req, busy, timeout} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h, required 0",
                     {bus.mem_ready, bus.mem_rdata, bus.rv_addr, bus.rv_din, bus.rv_ds, bus.rv_we, bus.rv_req, busy, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus.mem_ready) seen_ready = 1'b1;
        end
        checks++;
        if (seen_ready || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_ready: ready seen=%b busy=%b, required 0 0", seen_ready, busy);
        end
        lat = 2;
        access(23'h066000, 32'h0, 4'h0, 1'b0, rd, n, rc);
        checks++;
        if (rd !== 32'hABCD1234) begin
            errors++;
            $display("FAIL midrst_recover: got %h, required abcd1234", rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_writes();
        test_back_to_back();
        test_random();
`ifdef RV_SDRAM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
